// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD number-conversion datapath.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd2bin_state_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // True when a nibble is not a legal decimal digit.
    function automatic logic digit_invalid(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_mul10_add.sv
// One Horner step of BCD-to-binary conversion: result = acc*10 + digit.
// carryOut flags that the exact step result does not fit in WIDTH bits.
module bcd_mul10_add
    import bcd_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  bcd_digit_t       digit,
    output logic [WIDTH-1:0] result,
    output logic             carryOut
);

    logic [WIDTH+3:0] wide_s;

    // acc*10 as (acc<<3)+(acc<<1); four guard bits hold any carry since 10*acc+15 < 16*2^WIDTH
    always_comb begin
        wide_s = ({4'b0000, acc} << 32'd3) + ({4'b0000, acc} << 32'd1) + {{WIDTH{1'b0}}, digit};
    end

    assign result   = wide_s[WIDTH-1:0];
    assign carryOut = |wide_s[WIDTH+3:WIDTH];

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
// Optional build macro BCD_DIGIT_CHECK_EN enables detection of digits above 9.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int binaryNumberWidth = 32,
    parameter int numberOfDigits    = 6
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 load,
    input  logic [numberOfDigits-1:0][3:0]       BinaryDecimal,
    output logic [binaryNumberWidth-1:0]         binaryNumber,
    output logic                                 busy,
    output logic                                 enaOut,
    output logic                                 overflow,
    output logic                                 digitError
);

    localparam int CNT_W = (numberOfDigits > 1) ? $clog2(numberOfDigits) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(numberOfDigits - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    bcd2bin_state_t                     state_r;
    logic [binaryNumberWidth-1:0]       acc_r;
    logic [numberOfDigits*4-1:0]        shift_r;
    logic [CNT_W-1:0]                   cnt_r;
    logic                               ovf_r;
    logic                               derr_r;

    bcd_digit_t                         msd_s;
    logic [binaryNumberWidth-1:0]       accNext_s;
    logic                               stepCarry_s;
    logic                               digitBad_s;
    logic                               ovfNext_s;
    logic                               derrNext_s;

    assign msd_s = shift_r[numberOfDigits*4-1 -: 4];

    bcd_mul10_add #(
        .WIDTH (binaryNumberWidth)
    ) u_step (
        .acc      (acc_r),
        .digit    (msd_s),
        .result   (accNext_s),
        .carryOut (stepCarry_s)
    );

`ifdef BCD_DIGIT_CHECK_EN
    assign digitBad_s = digit_invalid(msd_s);
`else
    assign digitBad_s = 1'b0;
`endif

    assign ovfNext_s  = ovf_r | stepCarry_s;
    assign derrNext_s = derr_r | digitBad_s;

    // Conversion FSM, datapath registers and registered outputs; load overrides completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            acc_r        <= {binaryNumberWidth{1'b0}};
            shift_r      <= {(numberOfDigits*4){1'b0}};
            cnt_r        <= CNT_ZERO;
            ovf_r        <= 1'b0;
            derr_r       <= 1'b0;
            binaryNumber <= {binaryNumberWidth{1'b0}};
            busy         <= 1'b0;
            enaOut       <= 1'b0;
            overflow     <= 1'b0;
            digitError   <= 1'b0;
        end else if (load) begin
            state_r <= CONVERT;
            acc_r   <= {binaryNumberWidth{1'b0}};
            shift_r <= BinaryDecimal;
            cnt_r   <= CNT_LAST;
            ovf_r   <= 1'b0;
            derr_r  <= 1'b0;
            busy    <= 1'b1;
            enaOut  <= 1'b0;
        end else begin
            case (state_r)
                CONVERT: begin
                    acc_r   <= accNext_s;
                    ovf_r   <= ovfNext_s;
                    derr_r  <= derrNext_s;
                    shift_r <= shift_r << 32'd4;
                    if (cnt_r == CNT_ZERO) begin
                        state_r      <= DONE;
                        binaryNumber <= accNext_s;
                        overflow     <= ovfNext_s;
                        digitError   <= derrNext_s;
                        busy         <= 1'b0;
                        enaOut       <= 1'b1;
                    end else begin
                        cnt_r  <= cnt_r - CNT_ONE;
                        enaOut <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    enaOut  <= 1'b0;
                end
                IDLE: begin
                    busy   <= 1'b0;
                    enaOut <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    enaOut  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: a 32-bit and a 16-bit instance share stimulus
// and are checked against a plain-arithmetic decimal reference model.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [23:0] bcdWord = 24'h0;

    logic [31:0] bn32;
    logic        busy32, ena32, ovf32, derr32;
    logic [15:0] bn16;
    logic        busy16, ena16, ovf16, derr16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_to_binary #(.binaryNumberWidth(32), .numberOfDigits(6)) dut (
        .clk(clk), .rst(rst), .load(load), .BinaryDecimal(bcdWord),
        .binaryNumber(bn32), .busy(busy32), .enaOut(ena32),
        .overflow(ovf32), .digitError(derr32)
    );

    bcd_to_binary #(.binaryNumberWidth(16), .numberOfDigits(6)) dut16 (
        .clk(clk), .rst(rst), .load(load), .BinaryDecimal(bcdWord),
        .binaryNumber(bn16), .busy(busy16), .enaOut(ena16),
        .overflow(ovf16), .digitError(derr16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Exact decimal value of a 6-nibble word, each nibble weighted by its power of ten.
    function automatic longint unsigned decValue(input logic [23:0] w);
        longint unsigned v = 0;
        logic [3:0] d;
        for (int i = 5; i >= 0; i--) begin
            d = w[i*4 +: 4];
            v = v * 10 + longint'(d);
        end
        return v;
    endfunction

    function automatic logic anyBadDigit(input logic [23:0] w);
        logic bad = 1'b0;
        logic [3:0] d;
        for (int i = 0; i < 6; i++) begin
            d = w[i*4 +: 4];
            if (d > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic expDigitErr(input logic [23:0] w);
`ifdef BCD_DIGIT_CHECK_EN
        return anyBadDigit(w);
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge: load is sampled at the next posedge (E0); returns at the negedge after E0.
    task automatic startLoad(input logic [23:0] w);
        bcdWord = w;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bcdWord = 24'($urandom);
    endtask

    // From the negedge after E0, wait (bounded) for completion and check timing and results.
    task automatic waitDone(input string tag, input logic [23:0] w);
        int lat = 0;
        int busyCnt = 0;
        longint unsigned v = decValue(w);
        check({tag, "_ena_low_at_start"}, {63'd0, ena32}, 64'd0);
        while (!ena32 && lat < 20) begin
            if (busy32) busyCnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_ena32"}, {63'd0, ena32}, 64'd1);
        check({tag, "_ena16"}, {63'd0, ena16}, 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'd6);
        check({tag, "_busy_cycles"}, 64'(busyCnt), 64'd6);
        check({tag, "_busy_done"}, {62'd0, busy32, busy16}, 64'd0);
        check({tag, "_bn32"}, {32'd0, bn32}, v & 64'hFFFF_FFFF);
        check({tag, "_ovf32"}, {63'd0, ovf32}, {63'd0, v >= 64'h1_0000_0000});
        check({tag, "_bn16"}, {48'd0, bn16}, v & 64'hFFFF);
        check({tag, "_ovf16"}, {63'd0, ovf16}, {63'd0, v >= 64'h1_0000});
        check({tag, "_derr"}, {62'd0, derr32, derr16}, {62'd0, expDigitErr(w), expDigitErr(w)});
    endtask

    task automatic runConv(input string tag, input logic [23:0] w);
        longint unsigned v = decValue(w);
        startLoad(w);
        waitDone(tag, w);
        @(negedge clk);
        check({tag, "_ena_one_cycle"}, {63'd0, ena32}, 64'd0);
        check({tag, "_hold"}, {32'd0, bn32}, v & 64'hFFFF_FFFF);
    endtask

    initial begin
        logic [23:0] w;
        logic [31:0] prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outs32", {bn32, busy32, ena32, ovf32, derr32}, 64'd0);
        check("reset_outs16", {bn16, busy16, ena16, ovf16, derr16}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed cases from the decimal examples
        runConv("d123456", 24'h123456);
        runConv("d999999", 24'h999999);
        runConv("d000000", 24'h000000);
        runConv("d070000", 24'h070000);
        runConv("d065535", 24'h065535);
        runConv("d00A001", 24'h00A001);

        // Restart mid-conversion: only the second word completes
        startLoad(24'h111111);
        repeat (2) begin
            @(negedge clk);
            check("abort_no_ena", {63'd0, ena32}, 64'd0);
        end
        runConv("d000042", 24'h000042);

        // Load coinciding with the last digit wins: no pulse, result held
        prev = bn32;
        startLoad(24'h555555);
        repeat (5) @(negedge clk);
        startLoad(24'h000314);
        check("prio_no_ena", {63'd0, ena32}, 64'd0);
        check("prio_bn_held", {32'd0, bn32}, {32'd0, prev});
        check("prio_busy", {63'd0, busy32}, 64'd1);
        waitDone("prio", 24'h000314);

        // Load during DONE starts the next conversion back-to-back
        startLoad(24'h000007);
        waitDone("b2b", 24'h000007);
        @(negedge clk);

        // Reset mid-conversion discards everything
        startLoad(24'h123456);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_outs32", {bn32, busy32, ena32, ovf32, derr32}, 64'd0);
        check("midrst_outs16", {bn16, busy16, ena16, ovf16, derr16}, 64'd0);
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("midrst_quiet", {62'd0, ena32, busy32}, 64'd0);
        end

        // Randomized words, occasionally with illegal digits
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 6; i++) begin
                if ($urandom_range(0, 7) == 0)
                    w[i*4 +: 4] = 4'($urandom_range(10, 15));
                else
                    w[i*4 +: 4] = 4'($urandom_range(0, 9));
            end
            runConv("rand", w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
